// File: rtl/cone_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cone_seq_pkg
// Description : Shared widths and the FSM state encoding for the cone
//               evaluation sequencer and its combinational cone.
// Contents    : VEC_W     - width of an evaluated vector (7)
//               CNT_W     - width of the sweep ones counter (8)
//               SETTLE_W  - width of the settle down-counter (4)
//               state_t   - FSM state type, ST_* encodings
// Revision    : 1.0 - initial release
// ============================================================================
package cone_seq_pkg;

  localparam int VEC_W    = 7;
  localparam int CNT_W    = 8;
  localparam int SETTLE_W = 4;

  // Last vector of an exhaustive sweep; the generator wraps to 0 after it.
  localparam logic [VEC_W-1:0] VEC_LAST = 7'h7F;

  // State encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SETTLE  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

endpackage : cone_seq_pkg
`default_nettype wire

// File: rtl/cone_logic.sv
`default_nettype none
// ============================================================================
// Module      : cone_logic
// Description : Purely combinational logic cone under evaluation:
//                 b = NOR( AND( OR(!a0, a1&a2), OR(a3,a4) ), NAND(a5,a6) )
// Ports       : vec [6:0] in  - operand vector, bit 0 is a0
//               b         out - cone result
// Revision    : 1.0 - initial release
// ============================================================================
module cone_logic
  import cone_seq_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             b
);

  logic w_or_low;
  logic w_or_mid;
  logic w_and_term;
  logic w_nand_hi;

  assign w_or_low   = ~vec[0] | (vec[1] & vec[2]);
  assign w_or_mid   = vec[3] | vec[4];
  assign w_and_term = w_or_low & w_or_mid;
  assign w_nand_hi  = ~(vec[5] & vec[6]);
  assign b          = ~(w_and_term | w_nand_hi);

endmodule : cone_logic
`default_nettype wire

// File: rtl/cone_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cone_eval_sequencer
// Description : Launches a 7-bit vector into a combinational cone, waits
//               SETTLE_CYCLES cycles, captures the result and hands it out
//               over a valid/ready pair. Optional exhaustive-sweep engine
//               counts how many of the 128 vectors give b=1.
// Macro       : CONE_SWEEP_EN - compiles in the sweep engine; when undefined
//               sweep_start is ignored and the sweep outputs are tied 0.
// Parameters  : SETTLE_CYCLES - launch-to-capture settle time, 1..15
// Ports       : clk          in  - clock, rising edge
//               rst          in  - synchronous active-high reset
//               in_valid     in  - vector offered
//               in_vec[6:0]  in  - vector to evaluate, bit 0 is a0
//               in_ready     out - vector accepted this cycle
//               out_valid    out - result presented
//               out_ready    in  - consumer takes the result
//               out_vec[6:0] out - launched vector echo
//               out_b        out - captured cone result
//               sweep_start  in  - single-cycle sweep request
//               sweep_busy   out - sweep in progress
//               sweep_done   out - one-cycle pulse at sweep end
//               ones_count   out - b=1 count of the last sweep
// Revision    : 1.0 - initial release
// ============================================================================
module cone_eval_sequencer
  import cone_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [VEC_W-1:0] in_vec,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic             out_b,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [CNT_W-1:0] ones_count
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_settle_range_err
    $error("SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [SETTLE_W-1:0] C_SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

  state_t              r_state;
  logic [SETTLE_W-1:0] r_cnt;
  logic [VEC_W-1:0]    r_launch;

  logic             w_b;
  logic             w_idle;
  logic             w_capture;
  logic             w_accept;
  logic             w_sweep_go;
  logic             w_sweep_active;
  logic             w_sweep_last;
  logic [VEC_W-1:0] w_gen_next;

  // The cone only ever sees the launch register, so in_vec may change
  // freely once a vector has been accepted.
  cone_logic u_cone (
    .vec (r_launch),
    .b   (w_b)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign w_capture = (r_state == ST_CAPTURE);

  // A sweep request in the same cycle as an offered vector wins, so the
  // vector is refused rather than silently dropped.
  assign in_ready  = w_idle && !sweep_busy && !w_sweep_go;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);

`ifdef CONE_SWEEP_EN
  logic [VEC_W-1:0] r_gen;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_ones;

  assign w_sweep_go     = w_idle && !r_busy && sweep_start;
  assign w_sweep_active = r_busy;
  assign w_sweep_last   = (r_gen == VEC_LAST);
  assign w_gen_next     = r_gen + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gen  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_ones <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_sweep_go) begin
        r_gen  <= '0;
        r_busy <= 1'b1;
        r_ones <= '0;
      end else if (r_busy && w_capture) begin
        // Generator naturally wraps 127 -> 0 at the final capture.
        r_gen <= w_gen_next;
        if (w_b) begin
          r_ones <= r_ones + 1'b1;
        end
        if (w_sweep_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign sweep_busy = r_busy;
  assign sweep_done = r_done;
  assign ones_count = r_ones;
`else
  logic w_unused_sweep_start;

  assign w_unused_sweep_start = sweep_start;
  assign w_sweep_go           = 1'b0;
  assign w_sweep_active       = 1'b0;
  assign w_sweep_last         = 1'b0;
  assign w_gen_next           = '0;
  assign sweep_busy           = 1'b0;
  assign sweep_done           = 1'b0;
  assign ones_count           = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_launch <= '0;
      out_vec  <= '0;
      out_b    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sweep_go) begin
            r_launch <= '0;
            r_cnt    <= C_SETTLE_INIT;
            r_state  <= ST_SETTLE;
          end else if (w_accept) begin
            r_launch <= in_vec;
            r_cnt    <= C_SETTLE_INIT;
            r_state  <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == 1) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_sweep_active) begin
            // Sweep captures feed only the ones counter; the result
            // outputs keep their last handed-out value.
            if (w_sweep_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_launch <= w_gen_next;
              r_cnt    <= C_SETTLE_INIT;
              r_state  <= ST_SETTLE;
            end
          end else begin
            out_vec <= r_launch;
            out_b   <= w_b;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : cone_eval_sequencer
`default_nettype wire

// File: tb/tb_cone_eval_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cone_eval_sequencer
// Description : Self-checking bench for cone_eval_sequencer: directed vector
//               table, randomized vectors against a reference model of the
//               cone, reset corner cases and the optional sweep engine
//               (CONE_SWEEP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cone_eval_sequencer;

  localparam int SETTLE = 2;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [6:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_vec;
  logic       out_b;
  logic       sweep_start;
  logic       sweep_busy;
  logic       sweep_done;
  logic [7:0] ones_count;

  int checks = 0;
  int errors = 0;

  cone_eval_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_vec      (in_vec),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_vec     (out_vec),
    .out_b       (out_b),
    .sweep_start (sweep_start),
    .sweep_busy  (sweep_busy),
    .sweep_done  (sweep_done),
    .ones_count  (ones_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] vec;
    logic       exp_b;
    int         hold;
  } vec_rec_t;

  // Reference cone straight from the boolean description.
  function automatic logic ref_cone(input logic [6:0] v);
    bit a0, a1, a2, a3, a4, a5, a6;
    bit and_term, nand_term;
    a0 = v[0]; a1 = v[1]; a2 = v[2]; a3 = v[3];
    a4 = v[4]; a5 = v[5]; a6 = v[6];
    and_term  = ((!a0) || (a1 && a2)) && (a3 || a4);
    nand_term = !(a5 && a6);
    return !(and_term || nand_term);
  endfunction

  function automatic int ref_sweep_ones();
    int n = 0;
    for (int i = 0; i < 128; i++) begin
      if (ref_cone(7'(i))) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [6:0] v);
    int k = 0;
    while (!in_ready && k < 50) begin
      tick();
      k++;
    end
    check("ready_before_launch", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
  endtask

  // Full transaction: accept, latency, result, back-pressure, release.
  task automatic run_vector(input logic [6:0] v, input logic exp_b,
                            input int hold, input string tag);
    int         k;
    logic       ok;
    logic       sb;
    logic [6:0] sv;
    launch(v);
    // Keep offering decoys while busy; they must be ignored.
    k = 0;
    while (!out_valid && k < 40) begin
      in_valid = 1'b1;
      in_vec   = 7'($urandom);
      tick();
      k++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, k, SETTLE + 1);
    check({tag, "_out_b"}, {31'd0, out_b}, {31'd0, exp_b});
    check({tag, "_out_vec"}, {25'd0, out_vec}, {25'd0, v});
    ok = 1'b1;
    sb = out_b;
    sv = out_vec;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || out_b !== sb || out_vec !== sv || in_ready) ok = 1'b0;
    end
    if (hold > 0) check({tag, "_hold_stable"}, {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    #1;
    check({tag, "_no_same_cycle_ready"}, {31'd0, in_ready}, 32'd0);
    tick();
    out_ready = 1'b0;
    check({tag, "_released_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_released_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  vec_rec_t table_q[$];

  initial begin
    int         k;
    int         pulses;
    logic       saw_valid;
    logic [6:0] rv;

    table_q.push_back('{7'h60, 1'b1, 1});
    table_q.push_back('{7'h7F, 1'b0, 0});
    table_q.push_back('{7'h00, 1'b0, 2});
    table_q.push_back('{7'h61, 1'b1, 10});
    table_q.push_back('{7'h68, 1'b0, 0});
    table_q.push_back('{7'h79, 1'b1, 3});
    table_q.push_back('{7'h7E, 1'b0, 1});
    table_q.push_back('{7'h1F, 1'b0, 0});

    rst         = 1'b1;
    in_valid    = 1'b0;
    in_vec      = 7'h00;
    out_ready   = 1'b0;
    sweep_start = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_b", {31'd0, out_b}, 32'd0);
    check("reset_out_vec", {25'd0, out_vec}, 32'd0);
    check("reset_sweep_busy", {31'd0, sweep_busy}, 32'd0);
    check("reset_sweep_done", {31'd0, sweep_done}, 32'd0);
    check("reset_ones", {24'd0, ones_count}, 32'd0);

    foreach (table_q[i]) begin
      run_vector(table_q[i].vec, table_q[i].exp_b, table_q[i].hold,
                 $sformatf("tbl%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      rv = 7'($urandom);
      run_vector(rv, ref_cone(rv), int'($urandom_range(0, 3)),
                 $sformatf("rnd%0d", i));
    end

    // Reset while settling.
    launch(7'h7F);
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_settle_valid", {31'd0, out_valid}, 32'd0);
    check("rst_settle_ready", {31'd0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_settle_no_result", {31'd0, saw_valid}, 32'd0);
    run_vector(7'h60, 1'b1, 2, "post_rst_settle");

    // Reset while a result is pending.
    launch(7'h61);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
    check("pending_reached", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_done_out_b", {31'd0, out_b}, 32'd0);
    check("rst_done_out_vec", {25'd0, out_vec}, 32'd0);
    saw_valid = out_valid;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("rst_done_discarded", {31'd0, saw_valid}, 32'd0);

`ifdef CONE_SWEEP_EN
    // Sweep request competes with an offered vector and must win.
    sweep_start = 1'b1;
    in_valid    = 1'b1;
    in_vec      = 7'h60;
    #1;
    check("sweep_blocks_ready", {31'd0, in_ready}, 32'd0);
    tick();
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    check("sweep_busy_set", {31'd0, sweep_busy}, 32'd1);
    check("sweep_ones_cleared", {24'd0, ones_count}, 32'd0);
    pulses    = 0;
    saw_valid = 1'b0;
    k         = 0;
    while (pulses == 0 && k < 4000) begin
      tick();
      k++;
      if (sweep_done) pulses++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("sweep_ones", {24'd0, ones_count}, ref_sweep_ones());
    check("sweep_busy_clear", {31'd0, sweep_busy}, 32'd0);
    check("sweep_cycles", k, 128 * (SETTLE + 1));
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sweep_done) pulses++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("sweep_done_pulses", pulses, 1);
    check("sweep_no_out_valid", {31'd0, saw_valid}, 32'd0);
    check("sweep_ones_held", {24'd0, ones_count}, 32'd17);

    // Reset in the middle of a sweep.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    repeat (50) tick();
    check("midsweep_busy", {31'd0, sweep_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_sweep_busy", {31'd0, sweep_busy}, 32'd0);
    check("rst_sweep_ones", {24'd0, ones_count}, 32'd0);
    check("rst_sweep_ready", {31'd0, in_ready}, 32'd1);
`else
    // Without the engine the request is inert.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    pulses    = 0;
    saw_valid = 1'b0;
    k         = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (sweep_done) pulses++;
      if (sweep_busy) k++;
      if (out_valid) saw_valid = 1'b1;
    end
    check("nosweep_ones", {24'd0, ones_count}, 32'd0);
    check("nosweep_done", pulses, 0);
    check("nosweep_busy", k, 0);
    check("nosweep_no_valid", {31'd0, saw_valid}, 32'd0);
    check("nosweep_ready", {31'd0, in_ready}, 32'd1);
`endif

    run_vector(7'h00, 1'b0, 1, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_cone_eval_sequencer
`default_nettype wire

// File: doc/cone_eval_sequencer.md
CONE_EVAL_SEQUENCER -- requirements
Module: cone_eval_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles between vector launch and result capture (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all flops are rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning a vector is offered.
REQ-005 SHALL have port in_vec, input, 7, meaning the vector to evaluate; bit 0 is a0.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a vector this cycle.
REQ-007 SHALL have port out_valid, output, 1, meaning a result is presented.
REQ-008 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-009 SHALL have port out_vec, output, 7, echoing the launched vector.
REQ-010 SHALL have port out_b, output, 1, carrying the captured cone result.
REQ-011 SHALL have port sweep_start, input, 1, a single-cycle request for an exhaustive sweep.
REQ-012 SHALL have port sweep_busy, output, 1, high while a sweep runs.
REQ-013 SHALL have port sweep_done, output, 1, a one-cycle pulse when a sweep ends.
REQ-014 SHALL have port ones_count, output, 8, the number of vectors in the last sweep giving b=1.

Function
REQ-015 The cone SHALL compute b = NOR(AND(OR(NOT a0, AND(a1,a2)), OR(a3,a4)), NAND(a5,a6)) from the launch register only.
REQ-016 The FSM SHALL have states IDLE, SETTLE, CAPTURE and DONE.
REQ-017 in_ready SHALL be high only in IDLE while sweep_busy is low.
REQ-018 On in_valid&in_ready, the launch register SHALL load in_vec, a settle counter SHALL load SETTLE_CYCLES, and the FSM SHALL go IDLE->SETTLE.
REQ-019 In SETTLE, the counter SHALL decrement each cycle; at count 1 the FSM SHALL go to CAPTURE.
REQ-020 At the CAPTURE edge, out_b/out_vec SHALL load and the FSM SHALL go to DONE, making out_valid rise exactly SETTLE_CYCLES+1 cycles after the accept edge.
REQ-021 In DONE, out_valid, out_vec and out_b SHALL hold stable until out_valid&out_ready, then the FSM SHALL go to IDLE; in_ready SHALL be low in that same cycle (no same-cycle re-accept).
REQ-022 in_valid SHALL be ignored outside IDLE; in_vec changes after acceptance SHALL not affect the result.

Reset
REQ-023 rst SHALL force IDLE, out_valid=0, out_b=0, out_vec=0, launch register=0, sweep_busy=0, sweep_done=0 and ones_count=0 at the next edge, from any state, including mid-settle or mid-sweep.
REQ-024 A result pending in DONE SHALL be discarded by reset without out_valid being re-asserted.

Configuration
REQ-025 Macro CONE_SWEEP_EN SHALL compile in the sweep engine.
REQ-026 With CONE_SWEEP_EN, sweep_start in IDLE SHALL step an internal 7-bit generator 0..127 through the SETTLE/CAPTURE timing per vector, without asserting out_valid.
REQ-027 During a sweep, ones_count SHALL clear at start and increment on each captured b=1; sweep_done SHALL pulse one cycle after vector 127 is captured, with the generator wrapping to 0.
REQ-028 If sweep_start and in_valid are both high in IDLE, sweep_start SHALL win and in_ready SHALL be low.
REQ-029 Without CONE_SWEEP_EN, sweep_start SHALL be ignored and sweep_busy, sweep_done and ones_count SHALL be tied 0; the port list SHALL be unchanged.

Structure
REQ-030 Package cone_seq_pkg SHALL hold the state enum, VEC_W=7, CNT_W=8 and the settle-counter width (4).
REQ-031 Sub-module cone_logic SHALL implement REQ-015 as a purely combinational block.

Verification
REQ-032 Vector 7'h60 accepted at cycle t with SETTLE_CYCLES=2 SHALL produce out_valid at t+3, with out_b=1 and out_vec=7'h60.
REQ-033 Vectors 7'h7F and 7'h00 SHALL each produce out_b=0.
REQ-034 With out_ready held low for 10 cycles, out_valid/out_b SHALL stay stable and in_ready low; after a single out_ready pulse, in_ready SHALL be high the following cycle.
REQ-035 rst asserted during SETTLE SHALL give IDLE, out_valid=0 and in_ready=1 on the next cycle, and a new vector SHALL then evaluate correctly.
REQ-036 With CONE_SWEEP_EN, sweep_start SHALL give ones_count=17 with one sweep_done pulse and out_valid never asserted; without the macro, ones_count SHALL stay 0.
REQ-037 sweep_start and in_valid high in the same IDLE cycle SHALL start a sweep and leave the vector unaccepted.
